// File: rtl/regfile_scoreboard.sv
// Y86-64 register file with two read ports, two write ports and a per-register pending-write
// scoreboard that stalls issue on RAW hazards. Define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_scoreboard #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int PEND_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         src_a,
  input  logic [ADDR_W-1:0]         src_b,
  output logic [DATA_W-1:0]         val_a,
  output logic [DATA_W-1:0]         val_b,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_dst_e,
  input  logic [ADDR_W-1:0]         iss_dst_m,
  output logic                      stall,
  input  logic                      we_e,
  input  logic [ADDR_W-1:0]         dst_e,
  input  logic [DATA_W-1:0]         wdata_e,
  input  logic                      we_m,
  input  logic [ADDR_W-1:0]         dst_m,
  input  logic [DATA_W-1:0]         wdata_m,
  output logic [(1<<ADDR_W)-2:0]    busy,
  output logic                      sb_err
);
  localparam int NREGS = (1 << ADDR_W) - 1;
  localparam int CW    = PEND_W + 2;
  localparam logic [ADDR_W-1:0] RNONE    = '1;
  localparam logic [CW-1:0]     PEND_MAX = CW'((1 << PEND_W) - 1);

  logic [DATA_W-1:0] regs     [NREGS];
  logic [PEND_W-1:0] pend     [NREGS];
  logic [PEND_W-1:0] pend_nxt [NREGS];
  logic [1:0]        rel_cnt  [NREGS];
  logic [1:0]        inc_req  [NREGS];
  logic [1:0]        inc_acc  [NREGS];
  logic [NREGS-1:0]  hold;
  logic              hz_a, hz_b, sat, accept, err_set;

  // NOTE: every always_comb output gets a default before any conditional update, so no latches.
  always_comb begin
    hz_a  = 1'b0;
    hz_b  = 1'b0;
    sat   = 1'b0;
    val_a = '0;
    val_b = '0;
    busy  = '0;
    hold  = '0;
    for (int r = 0; r < NREGS; r++) begin
      rel_cnt[r] = 2'(we_e && dst_e == ADDR_W'(r)) + 2'(we_m && dst_m == ADDR_W'(r));
      inc_req[r] = iss_valid ? 2'(iss_dst_e == ADDR_W'(r)) + 2'(iss_dst_m == ADDR_W'(r)) : 2'd0;
      busy[r]    = pend[r] != '0;
`ifdef REGFILE_BYPASS_EN
      // A release landing this cycle already satisfies one outstanding write.
      hold[r]    = CW'(pend[r]) > CW'(rel_cnt[r]);
`else
      hold[r]    = pend[r] != '0;
`endif
      hz_a = hz_a | (src_a == ADDR_W'(r) && hold[r]);
      hz_b = hz_b | (src_b == ADDR_W'(r) && hold[r]);
      sat  = sat | ((CW'(pend[r]) + CW'(inc_req[r])) > (PEND_MAX + CW'(rel_cnt[r])));
      if (src_a == ADDR_W'(r)) val_a = regs[r];
      if (src_b == ADDR_W'(r)) val_b = regs[r];
    end
`ifdef REGFILE_BYPASS_EN
    if (src_a != RNONE && we_e && dst_e == src_a) val_a = wdata_e;
    if (src_a != RNONE && we_m && dst_m == src_a) val_a = wdata_m;
    if (src_b != RNONE && we_e && dst_e == src_b) val_b = wdata_e;
    if (src_b != RNONE && we_m && dst_m == src_b) val_b = wdata_m;
`endif
  end

  assign stall  = iss_valid & (hz_a | hz_b | sat);
  assign accept = iss_valid & ~stall;

  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      inc_acc[r] = accept ? inc_req[r] : 2'd0;
      // An over-release clamps the old count to zero but keeps this cycle's reservations.
      if (CW'(rel_cnt[r]) > CW'(pend[r])) begin
        err_set     = 1'b1;
        pend_nxt[r] = PEND_W'(inc_acc[r]);
      end else begin
        pend_nxt[r] = PEND_W'(CW'(pend[r]) + CW'(inc_acc[r]) - CW'(rel_cnt[r]));
      end
    end
  end

  // NOTE: the architectural registers are reset along with the scoreboard, so reads after
  // reset return zero; this keeps the array in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err <= 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
    end else begin
      if (err_set) sb_err <= 1'b1;
      for (int r = 0; r < NREGS; r++) begin
        pend[r] <= pend_nxt[r];
        if (we_m && dst_m == ADDR_W'(r))      regs[r] <= wdata_m;
        else if (we_e && dst_e == ADDR_W'(r)) regs[r] <= wdata_e;
      end
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: per-cycle vector table through a scoreboard queue,
// then a hand-written asynchronous reset sequence. Expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
  localparam logic [3:0] N = 4'hF;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic [3:0]  src_a, src_b, iss_dst_e, iss_dst_m, dst_e, dst_m;
  logic [63:0] val_a, val_b, wdata_e, wdata_m;
  logic        iss_valid, stall, we_e, we_m, sb_err;
  logic [14:0] busy;

  regfile_scoreboard #(.DATA_W(64), .ADDR_W(4), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b), .val_a(val_a), .val_b(val_b),
    .iss_valid(iss_valid), .iss_dst_e(iss_dst_e), .iss_dst_m(iss_dst_m), .stall(stall),
    .we_e(we_e), .dst_e(dst_e), .wdata_e(wdata_e), .we_m(we_m), .dst_m(dst_m),
    .wdata_m(wdata_m), .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [3:0]  sa, sb;
    logic        iv;
    logic [3:0]  ie, im;
    logic        wee;
    logic [3:0]  de;
    logic [63:0] wde;
    logic        wem;
    logic [3:0]  dm;
    logic [63:0] wdm;
    logic [63:0] ea, eb;
    logic        es;
    logic [14:0] ebusy;
    logic        eerr;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];
  vec_t sb_q [$];
  vec_t exp_v;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [3:0] sa, sb, input logic iv,
                              input logic [3:0] ie, im, input logic wee, input logic [3:0] de,
                              input logic [63:0] wde, input logic wem, input logic [3:0] dm,
                              input logic [63:0] wdm, input logic [63:0] ea, eb,
                              input logic es, input logic [14:0] ebusy, input logic eerr);
    vec_t t;
    t.n = n; t.sa = sa; t.sb = sb; t.iv = iv; t.ie = ie; t.im = im;
    t.wee = wee; t.de = de; t.wde = wde; t.wem = wem; t.dm = dm; t.wdm = wdm;
    t.ea = ea; t.eb = eb; t.es = es; t.ebusy = ebusy; t.eerr = eerr;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    src_a = t.sa; src_b = t.sb; iss_valid = t.iv; iss_dst_e = t.ie; iss_dst_m = t.im;
    we_e = t.wee; dst_e = t.de; wdata_e = t.wde; we_m = t.wem; dst_m = t.dm; wdata_m = t.wdm;
  endtask

  // Outputs for each driven vector are compared mid-cycle, before the edge that commits it.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      check($sformatf("v%0d.val_a", exp_v.n), val_a, exp_v.ea);
      check($sformatf("v%0d.val_b", exp_v.n), val_b, exp_v.eb);
      check($sformatf("v%0d.stall", exp_v.n), 64'(stall), 64'(exp_v.es));
      check($sformatf("v%0d.busy", exp_v.n), 64'(busy), 64'(exp_v.ebusy));
      check($sformatf("v%0d.sb_err", exp_v.n), 64'(sb_err), 64'(exp_v.eerr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply(mk(0, N, N, 0, N, N, 0, N, 0, 0, N, 0, 0, 0, 0, 0, 0));
    //           n  sa sb iv ie im wee de wde        wem dm wdm       ea                  eb                es         busy      err
    tbl[0]  = mk(0,  N, N, 0, N, N, 0, N, 64'h0,    0, N, 64'h0,  64'h0,              64'h0,             0,         15'h0000, 0);
    tbl[1]  = mk(1,  N, N, 1, 3, N, 0, N, 64'h0,    0, N, 64'h0,  64'h0,              64'h0,             0,         15'h0000, 0);
    tbl[2]  = mk(2,  3, N, 0, N, N, 1, 3, 64'h1234, 0, N, 64'h0,  BYP ? 64'h1234 : 0, 64'h0,             0,         15'h0008, 0);
    tbl[3]  = mk(3,  3, N, 0, N, N, 0, N, 64'h0,    0, N, 64'h0,  64'h1234,           64'h0,             0,         15'h0000, 0);
    tbl[4]  = mk(4,  N, N, 1, 4, 4, 0, N, 64'h0,    0, N, 64'h0,  64'h0,              64'h0,             0,         15'h0000, 0);
    tbl[5]  = mk(5,  4, N, 0, N, N, 1, 4, 64'hAA,   1, 4, 64'hBB, BYP ? 64'hBB : 0,   64'h0,             0,         15'h0010, 0);
    tbl[6]  = mk(6,  4, 3, 0, N, N, 0, N, 64'h0,    0, N, 64'h0,  64'hBB,             64'h1234,          0,         15'h0000, 0);
    tbl[7]  = mk(7,  N, N, 1, 2, N, 0, N, 64'h0,    0, N, 64'h0,  64'h0,              64'h0,             0,         15'h0000, 0);
    tbl[8]  = mk(8,  2, N, 1, N, N, 0, N, 64'h0,    0, N, 64'h0,  64'h0,              64'h0,             1,         15'h0004, 0);
    tbl[9]  = mk(9,  2, N, 1, N, N, 1, 2, 64'h5555, 0, N, 64'h0,  BYP ? 64'h5555 : 0, 64'h0,             BYP ? 0 : 1, 15'h0004, 0);
    tbl[10] = mk(10, 2, N, 1, N, N, 0, N, 64'h0,    0, N, 64'h0,  64'h5555,           64'h0,             0,         15'h0000, 0);
    tbl[11] = mk(11, N, N, 1, 5, 5, 0, N, 64'h0,    0, N, 64'h0,  64'h0,              64'h0,             0,         15'h0000, 0);
    tbl[12] = mk(12, N, N, 1, 5, N, 0, N, 64'h0,    0, N, 64'h0,  64'h0,              64'h0,             0,         15'h0020, 0);
    tbl[13] = mk(13, N, N, 1, 5, N, 0, N, 64'h0,    0, N, 64'h0,  64'h0,              64'h0,             1,         15'h0020, 0);
    tbl[14] = mk(14, N, N, 1, 5, N, 0, N, 64'h0,    1, 5, 64'h77, 64'h0,              64'h0,             0,         15'h0020, 0);
    tbl[15] = mk(15, 5, N, 0, N, N, 1, 5, 64'h11,   1, 5, 64'h22, BYP ? 64'h22 : 64'h77, 64'h0,          0,         15'h0020, 0);
    tbl[16] = mk(16, 5, N, 0, N, N, 1, 5, 64'h33,   0, N, 64'h0,  BYP ? 64'h33 : 64'h22, 64'h0,          0,         15'h0020, 0);
    tbl[17] = mk(17, 5, N, 0, N, N, 0, N, 64'h0,    0, N, 64'h0,  64'h33,             64'h0,             0,         15'h0000, 0);
    tbl[18] = mk(18, N, 7, 0, N, N, 1, 7, 64'h99,   0, N, 64'h0,  64'h0,              BYP ? 64'h99 : 0,  0,         15'h0000, 0);
    tbl[19] = mk(19, N, 7, 0, N, N, 0, N, 64'h0,    0, N, 64'h0,  64'h0,              64'h99,            0,         15'h0000, 1);
    tbl[20] = mk(20, 7, N, 1, 7, N, 0, N, 64'h0,    0, N, 64'h0,  64'h99,             64'h0,             0,         15'h0000, 1);
    tbl[21] = mk(21, 7, N, 1, N, N, 0, N, 64'h0,    0, N, 64'h0,  64'h99,             64'h0,             1,         15'h0080, 1);

    #2 rst = 1'b1;
    #10 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      apply(tbl[i]);
      sb_q.push_back(tbl[i]);
    end
    @(negedge clk);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset in mid-cycle while reg 7 still has an outstanding write.
    apply(mk(99, 7, 4, 1, N, N, 0, N, 0, 0, N, 0, 0, 0, 0, 0, 0));
    #1;
    check("pre_rst.stall", 64'(stall), 64'd1);
    check("pre_rst.val_b", val_b, 64'hBB);
    rst = 1'b1;
    #1;
    check("rst.val_a", val_a, 64'h0);
    check("rst.val_b", val_b, 64'h0);
    check("rst.busy", 64'(busy), 64'h0);
    check("rst.sb_err", 64'(sb_err), 64'h0);
    check("rst.stall", 64'(stall), 64'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("post_rst.stall", 64'(stall), 64'h0);
    check("post_rst.busy", 64'(busy), 64'h0);
    check("post_rst.val_a", val_a, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
